spi_bus_arbiter: RTL

- Shares the single physical SPI bus (phy_sck, phy_mosi, phy_miso) between N_REQ SPI masters: temp sensor, e-ink and ADC.
- Grants the bus round-robin, one transaction at a time.
- Muxes the granted master's sck/mosi onto the pins, steers phy_miso back to that master only, and gates each device chip-select.
- Enforces a guard gap between transactions and a watchdog timeout.
- Replaces the ad-hoc enable-AND-OR bus sharing in top.

---
 rtl/spi_bus_pkg.sv | 26 ++
 rtl/spi_bus_arbiter_rr_pick.sv | 31 +++
 rtl/spi_bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/spi_bus_pkg.sv
// Shared constants for the SPI bus arbiter: FSM encoding, requester indices,
// timer width and a round-robin pointer helper.
package spi_bus_pkg;

  localparam int CNT_W = 16;
  localparam int PTR_W = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWNED = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam logic [PTR_W-1:0] REQ_TEMP = 2'd0;
  localparam logic [PTR_W-1:0] REQ_EINK = 2'd1;
  localparam logic [PTR_W-1:0] REQ_ADC  = 2'd2;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx, input int n);
    logic [PTR_W-1:0] nxt;
    if (int'(idx) >= n - 1) begin
      nxt = REQ_TEMP;
    end else begin
      nxt = idx + PTR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin select: first asserted request at or after the
// pointer, wrapping modulo N_REQ.
module rr_pick
  import spi_bus_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_win,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_idx;
  logic             w_hit;

  // Walk from the pointer upward; the first hit masks all later candidates.
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx        = PTR_W'((int'(i_ptr) + i) % N_REQ);
      w_hit        = i_req[w_idx] & ~o_valid;
      o_win[w_idx] = o_win[w_idx] | w_hit;
      o_valid      = o_valid | w_hit;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI pins: one master at a time, with a guard
// gap between owners and a watchdog that reclaims a hung grant.
module spi_bus_arbiter
  import spi_bus_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             sys_clk_pin,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic [N_REQ-1:0] sck_in,
  input  logic [N_REQ-1:0] mosi_in,
  input  logic [N_REQ-1:0] cs_n_in,
  output logic [N_REQ-1:0] miso_out,
  output logic [N_REQ-1:0] grant,
  output logic             phy_sck,
  output logic             phy_mosi,
  input  logic             phy_miso,
  output logic [N_REQ-1:0] phy_cs_n,
  output logic             busy,
  output logic             timeout_err,
  output logic [1:0]       timeout_id
);

  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_gidx;
  logic [N_REQ-1:0] r_grant;
  logic [CNT_W-1:0] r_wdog;
  logic [CNT_W-1:0] r_guard;
  logic             r_timeout_err;
  logic [1:0]       r_timeout_id;

  logic [N_REQ-1:0] w_win;
  logic             w_valid;
  logic [PTR_W-1:0] w_win_idx;
  logic             w_done_g;
  logic             w_req_g;
  logic             w_wd_hit;
  logic             w_release;
  logic             w_to_release;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  // One-hot winner to index for the grant index register.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_win_idx = w_win_idx | (PTR_W'(i) & {PTR_W{w_win[i]}});
    end
  end

  assign w_done_g     = done[r_gidx];
  assign w_req_g      = req[r_gidx];
  assign w_wd_hit     = (r_wdog == TO_LAST);
  assign w_release    = (r_state == ST_OWNED) & (w_done_g | ~w_req_g | w_wd_hit);
  // A clean finish or an abort on the terminal cycle is not a watchdog event.
  assign w_to_release = (r_state == ST_OWNED) & w_wd_hit & ~w_done_g & w_req_g;

  // Arbitration FSM with watchdog and guard counters.
  always_ff @(posedge sys_clk_pin or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= REQ_TEMP;
      r_gidx        <= REQ_TEMP;
      r_grant       <= '0;
      r_wdog        <= '0;
      r_guard       <= '0;
      r_timeout_err <= 1'b0;
      r_timeout_id  <= 2'd0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant <= w_win;
            r_gidx  <= w_win_idx;
            r_wdog  <= '0;
            r_state <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (w_release) begin
            r_grant <= '0;
            r_ptr   <= next_ptr(r_gidx, N_REQ);
            r_guard <= '0;
            r_state <= (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
            if (w_to_release) begin
              r_timeout_err <= 1'b1;
              r_timeout_id  <= r_gidx;
            end
          end else begin
            r_wdog <= r_wdog + CNT_W'(1);
          end
        end
        ST_GUARD: begin
          if (r_guard == GUARD_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_guard <= r_guard + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Pins are gated by the registered grant, so idle levels follow reset asynchronously.
  assign grant       = r_grant;
  assign phy_sck     = |(sck_in & r_grant);
  assign phy_mosi    = |(mosi_in & r_grant);
  assign phy_cs_n    = cs_n_in | ~r_grant;
  assign miso_out    = {N_REQ{phy_miso}} & r_grant;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout_err;
  assign timeout_id  = r_timeout_id;

endmodule
